regfile_wb_arbiter: RTL and testbench

Write-port scheduler for the register bank built from per-register flip-flop cells. Shares the bank's single write path among NREQ write-back requesters with round-robin arbitration, driving one-hot per-register ClockEnable strobes and a common write-data bus. It also runs a zero-fill sweep of every register after reset or on a soft-clear command, then returns to arbitration.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_pick.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the register-bank write-port logic.
//   - Default requester count, bank depth, address and data widths.
//   - FSM state encoding for the write-port scheduler.
package regfile_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  // SWEEP zero-fills the bank; RUN arbitrates write-back requests.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage : regfile_pkg

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. It searches the valid vector for the
//   first asserted index strictly after ptr, wrapping modulo N, so the
//   requester at ptr itself has the lowest priority.
// Ports:
//   valid  in   N   request vector
//   ptr    in   PW  index of the most recent winner
//   grant  out  N   one-hot grant (all zero when nothing is valid)
//   idx    out  PW  binary index of the granted requester
//   any    out  1   high when some requester is granted
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan N candidates starting just after ptr; the first valid one wins.
  always_comb begin
    logic [PW-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!any && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule : rr_pick

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-port scheduler for a register bank made of per-register flop
//   cells. NREQ write-back requesters share the bank's single write path
//   through round-robin arbitration. Each accepted write drives a one-hot
//   ClockEnable strobe (we) and a common data bus (wr_data) one cycle later.
//   After reset, or on clr, every register is zero-filled by a sweep that
//   strobes one register per cycle before arbitration resumes.
// Ports:
//   Clock      in   1        rising-edge clock
//   Reset      in   1        asynchronous, active-high reset
//   clr        in   1        soft clear, restarts the zero-fill sweep
//   req_valid  in   NREQ     per-requester write request
//   req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_data   in   NREQ*DW  packed data, requester i at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot accept (combinational)
//   we         out  NREGS    registered one-hot ClockEnable per register
//   wr_data    out  DW       registered write data to all cells
//   busy       out  1        high while the sweep is running
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               clr,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREGS-1:0]   we,
  output logic [DW-1:0]      wr_data,
  output logic               busy
);

  localparam int              PW       = $clog2(NREQ);
  // Pointer starts at the last requester so requester 0 wins first.
  localparam logic [PW-1:0]   PTR_RST  = PW'(NREQ - 1);
  localparam logic [AW-1:0]   CNT_LAST = AW'(NREGS - 1);
  // One extra bit so addresses beyond the bank can be detected even when
  // NREGS equals 2**AW.
  localparam logic [AW:0]     NREGS_W  = (AW + 1)'(NREGS);
  localparam logic [NREGS-1:0] WE_ONE  = {{(NREGS - 1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREGS-1:0] we_q, we_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;

  logic [NREQ-1:0]  pick_grant;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             arb_en;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are offered only in RUN; clr overrides arbitration for the cycle.
  always_comb begin
    arb_en    = (state_q == ST_RUN) && !clr;
    req_ready = arb_en ? pick_grant : {NREQ{1'b0}};
    sel_addr  = req_addr[int'(pick_idx) * AW +: AW];
    sel_data  = req_data[int'(pick_idx) * DW +: DW];
  end

  // Next-state, counter, pointer and output-register computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    we_d      = {NREGS{1'b0}};
    wr_data_d = wr_data_q;
    case (state_q)
      ST_SWEEP: begin
        if (clr) begin
          cnt_d = {AW{1'b0}};
        end else begin
          we_d      = WE_ONE << cnt_q;
          wr_data_d = {DW{1'b0}};
          if (cnt_q == CNT_LAST) begin
            cnt_d   = {AW{1'b0}};
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_SWEEP;
          cnt_d   = {AW{1'b0}};
        end else if (pick_any) begin
          ptr_d = pick_idx;
          // Register 0 and out-of-bank addresses are accepted but never
          // strobed; the data bus keeps its last value for them.
          if ((sel_addr != {AW{1'b0}}) && ({1'b0, sel_addr} < NREGS_W)) begin
            we_d      = WE_ONE << sel_addr;
            wr_data_d = sel_data;
          end else begin
            we_d = {NREGS{1'b0}};
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_SWEEP;
      cnt_q     <= {AW{1'b0}};
      ptr_q     <= PTR_RST;
      we_q      <= {NREGS{1'b0}};
      wr_data_q <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign we      = we_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == ST_SWEEP);

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed self-checking bench for regfile_wb_arbiter with default
//   parameters (3 requesters, 32 registers, 5-bit address, 32-bit data).
module tb_regfile_wb_arbiter;

  logic        Clock;
  logic        Reset;
  logic        clr;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [31:0] we;
  logic [31:0] wr_data;
  logic        busy;

  int n_pass;
  int n_total;

  regfile_wb_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .clr       (clr),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic test_reset();
    logic [31:0] exp_we;
    logic        exp_busy;
    #1;
    n_total++; if (we !== 32'h0) $display("FAIL reset_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %h exp %h", wr_data, 32'h0); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy got %b exp %b", busy, 1'b1); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b exp %b", req_ready, 3'b000); else n_pass++;
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(posedge Clock); #1;
      exp_we   = 32'h1 << k;
      exp_busy = (k < 31) ? 1'b1 : 1'b0;
      n_total++; if (we !== exp_we) $display("FAIL sweep_we k=%0d got %h exp %h", k, we, exp_we); else n_pass++;
      n_total++; if (wr_data !== 32'h0) $display("FAIL sweep_data k=%0d got %h exp %h", k, wr_data, 32'h0); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL sweep_busy k=%0d got %b exp %b", k, busy, exp_busy); else n_pass++;
    end
    @(posedge Clock); #1;
    n_total++; if (we !== 32'h0) $display("FAIL idle_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp %b", busy, 1'b0); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [31:0] d [3];
    int          w;
    logic [31:0] exp_we;
    d[0] = 32'hAAAA0001;
    d[1] = 32'hBBBB0002;
    d[2] = 32'hCCCC0003;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {d[2], d[1], d[0]};
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      w = i % 3;
      #1;
      n_total++; if (req_ready !== (3'b001 << w)) $display("FAIL rr_ready i=%0d got %b exp %b", i, req_ready, 3'b001 << w); else n_pass++;
      @(posedge Clock); #1;
      exp_we = 32'h1 << (5 + w);
      n_total++; if (we !== exp_we) $display("FAIL rr_we i=%0d got %h exp %h", i, we, exp_we); else n_pass++;
      n_total++; if (wr_data !== d[w]) $display("FAIL rr_data i=%0d got %h exp %h", i, wr_data, d[w]); else n_pass++;
    end
    req_valid = 3'b000;
    #1;
    n_total++; if (req_ready !== 3'b000) $display("FAIL rr_idle_ready got %b exp %b", req_ready, 3'b000); else n_pass++;
    @(posedge Clock); #1;
    n_total++; if (we !== 32'h0) $display("FAIL rr_idle_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (wr_data !== 32'hCCCC0003) $display("FAIL rr_idle_data got %h exp %h", wr_data, 32'hCCCC0003); else n_pass++;
  endtask

  task automatic test_addr_zero();
    req_valid           = 3'b010;
    req_addr[5 +: 5]    = 5'd0;
    req_data[32 +: 32]  = 32'hDEADBEEF;
    #1;
    n_total++; if (req_ready !== 3'b010) $display("FAIL a0_ready got %b exp %b", req_ready, 3'b010); else n_pass++;
    @(posedge Clock); #1;
    req_valid = 3'b000;
    n_total++; if (we !== 32'h0) $display("FAIL a0_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (wr_data !== 32'hCCCC0003) $display("FAIL a0_data got %h exp %h", wr_data, 32'hCCCC0003); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic [31:0] exp_we;
    req_valid = 3'b100;
    for (int i = 0; i < 4; i++) begin
      req_addr[10 +: 5]  = 5'(9 + i);
      exp_data           = 32'h0B0B0000 + 32'(i);
      req_data[64 +: 32] = exp_data;
      #1;
      n_total++; if (req_ready !== 3'b100) $display("FAIL b2b_ready i=%0d got %b exp %b", i, req_ready, 3'b100); else n_pass++;
      @(posedge Clock); #1;
      exp_we = 32'h1 << (9 + i);
      n_total++; if (we !== exp_we) $display("FAIL b2b_we i=%0d got %h exp %h", i, we, exp_we); else n_pass++;
      n_total++; if (wr_data !== exp_data) $display("FAIL b2b_data i=%0d got %h exp %h", i, wr_data, exp_data); else n_pass++;
    end
    req_valid = 3'b000;
    @(posedge Clock); #1;
    n_total++; if (we !== 32'h0) $display("FAIL b2b_idle_we got %h exp %h", we, 32'h0); else n_pass++;
  endtask

  task automatic test_clr();
    logic [31:0] exp_we;
    req_valid         = 3'b001;
    req_addr[0 +: 5]  = 5'd3;
    req_data[0 +: 32] = 32'h11111111;
    clr               = 1'b1;
    #1;
    n_total++; if (req_ready !== 3'b000) $display("FAIL clr_ready got %b exp %b", req_ready, 3'b000); else n_pass++;
    @(posedge Clock); #1;
    clr = 1'b0;
    n_total++; if (we !== 32'h0) $display("FAIL clr_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL clr_busy got %b exp %b", busy, 1'b1); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      n_total++; if (req_ready !== 3'b000) $display("FAIL clr_sweep_ready k=%0d got %b exp %b", k, req_ready, 3'b000); else n_pass++;
      @(posedge Clock); #1;
      exp_we = 32'h1 << k;
      n_total++; if (we !== exp_we) $display("FAIL clr_sweep_we k=%0d got %h exp %h", k, we, exp_we); else n_pass++;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL clr_end_busy got %b exp %b", busy, 1'b0); else n_pass++;
    n_total++; if (req_ready !== 3'b001) $display("FAIL clr_end_ready got %b exp %b", req_ready, 3'b001); else n_pass++;
    @(posedge Clock); #1;
    req_valid = 3'b000;
    n_total++; if (we !== 32'h00000008) $display("FAIL clr_end_we got %h exp %h", we, 32'h00000008); else n_pass++;
    n_total++; if (wr_data !== 32'h11111111) $display("FAIL clr_end_data got %h exp %h", wr_data, 32'h11111111); else n_pass++;
  endtask

  task automatic test_skip();
    // Pointer sits at 0, so requester 2 must beat requester 0 and 1 is idle.
    req_valid          = 3'b101;
    req_addr[10 +: 5]  = 5'd20;
    req_data[64 +: 32] = 32'h22222222;
    #1;
    n_total++; if (req_ready !== 3'b100) $display("FAIL skip_ready0 got %b exp %b", req_ready, 3'b100); else n_pass++;
    @(posedge Clock); #1;
    n_total++; if (we !== 32'h00100000) $display("FAIL skip_we0 got %h exp %h", we, 32'h00100000); else n_pass++;
    n_total++; if (wr_data !== 32'h22222222) $display("FAIL skip_data0 got %h exp %h", wr_data, 32'h22222222); else n_pass++;
    n_total++; if (req_ready !== 3'b001) $display("FAIL skip_ready1 got %b exp %b", req_ready, 3'b001); else n_pass++;
    @(posedge Clock); #1;
    req_valid = 3'b000;
    n_total++; if (we !== 32'h00000008) $display("FAIL skip_we1 got %h exp %h", we, 32'h00000008); else n_pass++;
    n_total++; if (wr_data !== 32'h11111111) $display("FAIL skip_data1 got %h exp %h", wr_data, 32'h11111111); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    clr = 1'b1;
    @(posedge Clock); #1;
    clr = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    n_total++; if (we !== 32'h00000200) $display("FAIL mid_pre_we got %h exp %h", we, 32'h00000200); else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++; if (we !== 32'h0) $display("FAIL mid_rst_we got %h exp %h", we, 32'h0); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_rst_busy got %b exp %b", busy, 1'b1); else n_pass++;
    n_total++; if (wr_data !== 32'h0) $display("FAIL mid_rst_data got %h exp %h", wr_data, 32'h0); else n_pass++;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    n_total++; if (we !== 32'h00000001) $display("FAIL mid_restart_we got %h exp %h", we, 32'h00000001); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_restart_busy got %b exp %b", busy, 1'b1); else n_pass++;
    repeat (31) @(posedge Clock);
    #1;
    n_total++; if (we !== 32'h80000000) $display("FAIL mid_last_we got %h exp %h", we, 32'h80000000); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_last_busy got %b exp %b", busy, 1'b0); else n_pass++;
    // Reset put the pointer back at requester 2, so requester 0 wins.
    req_valid        = 3'b011;
    req_addr[0 +: 5] = 5'd3;
    req_addr[5 +: 5] = 5'd4;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL mid_ptr_ready got %b exp %b", req_ready, 3'b001); else n_pass++;
    @(posedge Clock); #1;
    req_valid = 3'b000;
    n_total++; if (we !== 32'h00000008) $display("FAIL mid_ptr_we got %h exp %h", we, 32'h00000008); else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    Reset     = 1'b1;
    clr       = 1'b0;
    req_valid = 3'b000;
    req_addr  = 15'h0;
    req_data  = 96'h0;
    test_reset();
    test_round_robin();
    test_addr_zero();
    test_back_to_back();
    test_clr();
    test_skip();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
